// File: rtl/freq_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : freq_gate_ctrl_if
//  Purpose  : Control/result bus of the gated two-channel edge counter.
//             The master drives measurement controls and the output byte
//             select. The slave returns the result byte and status.
//  Revision : 1.0 - initial release
// ============================================================================
interface freq_gate_ctrl_if #(
    parameter int GATE_SEL_W = 3
);
    logic                  start;
    logic                  abort;
    logic                  pause;
    logic                  cont;
    logic [GATE_SEL_W-1:0] gate_sel;
    logic [1:0]            sel;
    logic [7:0]            data_out;
    logic                  busy;
    logic                  done;
    logic [1:0]            ovf;

    modport master (
        output start, abort, pause, cont, gate_sel, sel,
        input  data_out, busy, done, ovf
    );

    modport slave (
        input  start, abort, pause, cont, gate_sel, sel,
        output data_out, busy, done, ovf
    );
endinterface
`default_nettype wire

// File: rtl/freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : freq_gate_ctrl
//  Purpose  : Gated measurement sequencer for two asynchronous inputs.
//             It opens a 2^(GATE_MIN_LOG2+gate_sel) cycle window and counts
//             both edges of sig1/sig2 while the window is open. It then
//             latches the counts and presents one selected result byte.
//  Revision : 1.0 - initial release
// ============================================================================
module freq_gate_ctrl #(
    parameter int CNT_W         = 16,
    parameter int GATE_MIN_LOG2 = 10,
    parameter int GATE_SEL_W    = 3
) (
    input  wire logic       clk25,
    input  wire logic       rst_n,
    input  wire logic       sig1,
    input  wire logic       sig2,
    freq_gate_ctrl_if.slave bus
);

    // The widest gate is 2^(GATE_MIN_LOG2 + 2^GATE_SEL_W - 1) cycles.
    // One spare timer bit therefore makes the terminal compare unreachable by wrap.
    localparam int                  c_tmr_w   = GATE_MIN_LOG2 + 2**GATE_SEL_W;
    localparam logic [GATE_SEL_W:0] c_span    = (GATE_SEL_W+1)'(2**GATE_SEL_W);
    localparam logic [c_tmr_w-1:0]  c_tmr_one = c_tmr_w'(1);
    localparam logic [c_tmr_w-1:0]  c_tmr_all = {c_tmr_w{1'b1}};
    localparam logic [CNT_W-1:0]    c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_cnt_max = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_GATE  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [2:0]            sync1_q,    sync1_d;
    logic [2:0]            sync2_q,    sync2_d;
    logic [CNT_W-1:0]      cnt1_q,     cnt1_d;
    logic [CNT_W-1:0]      cnt2_q,     cnt2_d;
    logic [c_tmr_w-1:0]    tmr_q,      tmr_d;
    logic [1:0]            live_ovf_q, live_ovf_d;
    logic [GATE_SEL_W-1:0] gsel_q,     gsel_d;
    logic [CNT_W-1:0]      res1_q,     res1_d;
    logic [CNT_W-1:0]      res2_q,     res2_d;
    logic [1:0]            ovf_q,      ovf_d;
    logic                  done_q,     done_d;

    logic                  w_edge1;
    logic                  w_edge2;
    logic [GATE_SEL_W:0]   w_tmr_shift;
    logic [c_tmr_w-1:0]    w_tmr_last;

    // Sync bit 0 is the first flop after the pin. An edge is the difference of the two oldest stages.
    assign w_edge1     = sync1_q[1] ^ sync1_q[2];
    assign w_edge2     = sync2_q[1] ^ sync2_q[2];
    assign w_tmr_shift = c_span - {1'b0, gsel_q};
    assign w_tmr_last  = c_tmr_all >> w_tmr_shift;

    // Next-state logic for the sequencer, counters and result registers
    always_comb begin
        state_d    = state_q;
        sync1_d    = {sync1_q[1:0], sig1};
        sync2_d    = {sync2_q[1:0], sig2};
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        tmr_d      = tmr_q;
        live_ovf_d = live_ovf_q;
        gsel_d     = gsel_q;
        res1_d     = res1_q;
        res2_d     = res2_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                cnt1_d     = '0;
                cnt2_d     = '0;
                tmr_d      = '0;
                live_ovf_d = 2'b00;
                gsel_d     = bus.gate_sel;
                state_d    = bus.abort ? ST_IDLE : ST_GATE;
            end

            ST_GATE: begin
                // Abort drops this cycle's edges and leaves published results alone
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (!bus.pause) begin
                    tmr_d = tmr_q + c_tmr_one;
                    if (w_edge1) begin
                        if (cnt1_q == c_cnt_max) begin
                            live_ovf_d[0] = 1'b1;
                        end else begin
                            cnt1_d = cnt1_q + c_cnt_one;
                        end
                    end
                    if (w_edge2) begin
                        if (cnt2_q == c_cnt_max) begin
                            live_ovf_d[1] = 1'b1;
                        end else begin
                            cnt2_d = cnt2_q + c_cnt_one;
                        end
                    end
                    if (tmr_q == w_tmr_last) begin
                        state_d = ST_LATCH;
                    end
                end
            end

            ST_LATCH: begin
                res1_d  = cnt1_q;
                res2_d  = cnt2_q;
                ovf_d   = live_ovf_q;
                done_d  = 1'b1;
                state_d = bus.cont ? ST_ARM : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register bank with asynchronous clear
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            tmr_q      <= '0;
            live_ovf_q <= 2'b00;
            gsel_q     <= '0;
            res1_q     <= '0;
            res2_q     <= '0;
            ovf_q      <= 2'b00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            tmr_q      <= tmr_d;
            live_ovf_q <= live_ovf_d;
            gsel_q     <= gsel_d;
            res1_q     <= res1_d;
            res2_q     <= res2_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Result byte mux driven straight from the result registers
    always_comb begin
        bus.data_out = 8'h00;
        case (bus.sel)
            2'b00:   bus.data_out = res1_q[0 +: 8];
            2'b01:   bus.data_out = res1_q[8 +: 8];
            2'b10:   bus.data_out = res2_q[0 +: 8];
            default: bus.data_out = res2_q[8 +: 8];
        endcase
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_gate_ctrl
//  Purpose  : Directed self-checking bench for freq_gate_ctrl.
//             It uses GATE_MIN_LOG2 = 4, so gate_sel = 0 gives a 16-cycle window.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_gate_ctrl;

    logic clk25 = 1'b0;
    logic rst_n;
    logic sig1;
    logic sig2;

    freq_gate_ctrl_if #(.GATE_SEL_W(3)) bus ();

    freq_gate_ctrl #(
        .CNT_W        (16),
        .GATE_MIN_LOG2(4),
        .GATE_SEL_W   (3)
    ) dut (
        .clk25(clk25),
        .rst_n(rst_n),
        .sig1 (sig1),
        .sig2 (sig2),
        .bus  (bus)
    );

    always #5 clk25 = ~clk25;

    int n_tests   = 0;
    int n_fail    = 0;
    int busy_acc  = 0;
    int done_acc  = 0;
    int sig1_mode = 0;   // 0 hold, 1 toggle every cycle, 2 toggle every 2 cycles
    int sig2_mode = 0;

    // Measured-signal generator, changes on the falling edge
    initial begin
        int phase;
        phase = 0;
        sig1  = 1'b0;
        sig2  = 1'b0;
        forever begin
            @(negedge clk25);
            phase++;
            if (sig1_mode == 1 || (sig1_mode == 2 && phase[0])) sig1 = ~sig1;
            if (sig2_mode == 1 || (sig2_mode == 2 && phase[0])) sig2 = ~sig2;
        end
    end

    // Busy-cycle and done-pulse accumulators
    initial begin
        forever begin
            @(negedge clk25);
            if (bus.busy === 1'b1) busy_acc++;
            if (bus.done === 1'b1) done_acc++;
        end
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [1:0] s, input logic [7:0] exp);
        bus.sel = s;
        #1;
        chk(tag, {24'h0, bus.data_out}, {24'h0, exp});
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk25);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && bus.done !== 1'b1; i++) @(negedge clk25);
        chk(tag, {31'h0, bus.done}, 32'h1);
    endtask

    initial begin
        int d0;
        int gap;
        int busy_low;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.pause    = 1'b0;
        bus.cont     = 1'b0;
        bus.gate_sel = 3'd0;
        bus.sel      = 2'b00;
        repeat (2) @(negedge clk25);

        // Reset state
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_ovf",  {30'h0, bus.ovf},  32'h0);
        chk_byte("rst_data", 2'b00, 8'h00);
        @(negedge clk25);
        rst_n = 1'b1;

        // Basic gate: sig1 every 2 cycles over 16 cycles -> exactly 8 edges
        sig1_mode = 2;
        sig2_mode = 0;
        repeat (4) @(negedge clk25);
        busy_acc = 0;
        d0 = done_acc;
        do_start();
        wait_done("t1_done", 40);
        chk_byte("t1_res1_lo", 2'b00, 8'h08);
        chk_byte("t1_res1_hi", 2'b01, 8'h00);
        chk_byte("t1_res2_lo", 2'b10, 8'h00);
        chk("t1_ovf", {30'h0, bus.ovf}, 32'h0);
        @(negedge clk25);
        chk("t1_done_width", {31'h0, bus.done}, 32'h0);
        chk("t1_busy_after", {31'h0, bus.busy}, 32'h0);
        chk("t1_busy_cycles", busy_acc, 32'd18);  // ARM + 16 GATE + LATCH
        chk("t1_done_count", done_acc - d0, 32'd1);

        // Abort mid-GATE keeps the prior result and emits no done
        do_start();
        repeat (4) @(negedge clk25);
        bus.abort = 1'b1;
        @(negedge clk25);
        chk("abort_idle", {31'h0, bus.busy}, 32'h0);
        bus.abort = 1'b0;
        d0 = done_acc;
        repeat (20) @(negedge clk25);
        chk("abort_no_done", done_acc - d0, 32'd0);
        chk_byte("abort_data", 2'b00, 8'h08);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk25);
        chk("start_abort_1", {31'h0, bus.busy}, 32'h0);
        @(negedge clk25);
        chk("start_abort_2", {31'h0, bus.busy}, 32'h0);
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // gate_sel=2 -> 64-cycle window. sig2 toggles every cycle. The mid-GATE gate_sel change is ignored.
        sig1_mode = 0;
        sig2_mode = 1;
        bus.gate_sel = 3'd2;
        repeat (4) @(negedge clk25);
        busy_acc = 0;
        d0 = done_acc;
        do_start();
        @(negedge clk25);
        bus.gate_sel = 3'd0;
        wait_done("t2_done", 120);
        chk_byte("t2_res2_lo", 2'b10, 8'h40);
        chk_byte("t2_res2_hi", 2'b11, 8'h00);
        chk_byte("t2_res1_lo", 2'b00, 8'h00);
        @(negedge clk25);
        chk("t2_busy_cycles", busy_acc, 32'd66);
        chk("t2_done_count", done_acc - d0, 32'd1);

        // Pause 10 cycles mid-GATE -> 26-cycle window, 16 counted edges
        sig2_mode = 0;
        sig1_mode = 1;
        bus.gate_sel = 3'd0;
        repeat (4) @(negedge clk25);
        busy_acc = 0;
        do_start();
        repeat (3) @(negedge clk25);
        bus.pause = 1'b1;
        repeat (10) @(negedge clk25);
        bus.pause = 1'b0;
        wait_done("t3_done", 60);
        chk_byte("t3_res1_lo", 2'b00, 8'h10);
        chk_byte("t3_res1_hi", 2'b01, 8'h00);
        chk_byte("t3_res2_lo", 2'b10, 8'h00);
        @(negedge clk25);
        chk("t3_busy_cycles", busy_acc, 32'd28);

        // Saturation: preload cnt1 near full while paused, then feed edges
        sig1_mode = 0;
        bus.gate_sel = 3'd2;
        repeat (4) @(negedge clk25);
        do_start();
        @(negedge clk25);
        bus.pause = 1'b1;
        @(negedge clk25);
        force dut.cnt1_q = 16'hFFFE;
        @(negedge clk25);
        release dut.cnt1_q;
        bus.pause = 1'b0;
        sig1_mode = 2;
        wait_done("sat_done", 120);
        chk_byte("sat_res1_lo", 2'b00, 8'hFF);
        chk_byte("sat_res1_hi", 2'b01, 8'hFF);
        chk_byte("sat_res2_lo", 2'b10, 8'h00);
        chk("sat_ovf", {30'h0, bus.ovf}, 32'h1);

        // Continuous mode: done every 18 cycles, never idle in between
        bus.gate_sel = 3'd0;
        bus.cont     = 1'b1;
        bus.sel      = 2'b00;
        repeat (4) @(negedge clk25);
        do_start();
        wait_done("cont_done1", 40);
        chk("cont_busy_at_done", {31'h0, bus.busy}, 32'h1);
        gap = 0;
        busy_low = 0;
        do begin
            @(negedge clk25);
            gap++;
            if (bus.busy !== 1'b1) busy_low = 1;
        end while (bus.done !== 1'b1 && gap < 60);
        chk("cont_period", gap, 32'd18);
        chk("cont_no_idle", busy_low, 32'd0);
        chk_byte("cont_res1", 2'b00, 8'h08);
        chk("cont_ovf_cleared", {30'h0, bus.ovf}, 32'h0);
        bus.cont = 1'b0;

        // Asynchronous reset in the middle of GATE
        repeat (5) @(negedge clk25);
        chk("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'h0, bus.busy}, 32'h0);
        chk("arst_done", {31'h0, bus.done}, 32'h0);
        chk("arst_ovf",  {30'h0, bus.ovf},  32'h0);
        chk("arst_data", {24'h0, bus.data_out}, 32'h0);
        @(negedge clk25);
        rst_n = 1'b1;
        @(negedge clk25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
